coproc_cmd_sched: RTL and testbench

- Command scheduler between the CPU memory-mapped I/O layer and the image coprocessor.
- Buffers coprocessor commands that the CPU writes into a small FIFO.
- Issues one command at a time: a single-cycle start pulse, sent only when the coprocessor reports ready.
- Tracks completion and exposes a status byte for CPU polling, plus a completion pulse.
- Result: the CPU can post several operations back-to-back without spinning on ready/done.

---
 rtl/coproc_cmd_sched.sv | 188 ++++++++++++++++++
 tb/tb_coproc_cmd_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_cmd_sched.sv
// coproc_cmd_sched: FIFO-buffered command scheduler between CPU MMIO and the image coprocessor.
// Optional start-to-done watchdog compiled in with `define COPROC_SCHED_TIMEOUT_EN.
module coproc_cmd_sched #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TO_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_wr,
    input  logic [7:0] cmd_data,
    input  logic       flush,
    input  logic       sts_clr,
    input  logic       cp_rdy,
    input  logic       cp_done,
    output logic       cp_start,
    output logic       cp_gray,
    output logic       cp_img_idx,
    output logic [2:0] cp_func,
    output logic [7:0] sts,
    output logic       irq_done
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [4:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            done_q;
    logic            ovf_flag;
    logic            to_flag;
    logic            to_hit;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;
    logic            ovf_set;
    logic            done_rise;
    logic            busy;
    logic [4:0]      cnt_ext;
    logic            unused_cmd_bits;

    assign unused_cmd_bits = ^{cmd_data[7], cmd_data[4:3]};

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign done_rise  = cp_done & ~done_q;

    // flush outranks both ends of the FIFO; a push at full survives only when a pop frees the slot
    assign pop     = (state == S_IDLE) && !fifo_empty && cp_rdy && !flush;
    assign push_ok = cmd_wr && !flush && (!fifo_full || pop);
    assign ovf_set = cmd_wr && !flush && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {cmd_data[6], cmd_data[5], cmd_data[2:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef COPROC_SCHED_TIMEOUT_EN
    localparam int unsigned TW      = $clog2(TO_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == S_ISSUE) begin
            to_cnt <= '0;
        end else if (state == S_RUN) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // a done edge in the final RUN cycle still counts as a normal completion
    assign to_hit = (state == S_RUN) && (to_cnt == TO_LAST) && !done_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_flag <= 1'b0;
        end else if (to_hit) begin
            to_flag <= 1'b1;
        end else if (sts_clr) begin
            to_flag <= 1'b0;
        end
    end
`else
    localparam int unsigned unused_to_cycles = TO_CYCLES;

    assign to_hit  = 1'b0;
    assign to_flag = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx = S_RUN;
            end
            S_RUN: begin
                if (done_rise || to_hit) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            done_q     <= 1'b0;
            irq_done   <= 1'b0;
            ovf_flag   <= 1'b0;
            cp_gray    <= 1'b0;
            cp_img_idx <= 1'b0;
            cp_func    <= '0;
        end else begin
            state    <= state_nx;
            done_q   <= cp_done;
            irq_done <= (state == S_RUN) && done_rise;
            if (ovf_set) begin
                ovf_flag <= 1'b1;
            end else if (sts_clr) begin
                ovf_flag <= 1'b0;
            end
            if (pop) begin
                {cp_gray, cp_img_idx, cp_func} <= mem[rd_ptr];
            end
        end
    end

    assign cp_start = (state == S_ISSUE);
    assign busy     = (state != S_IDLE);

    // a full 16-deep FIFO cannot be shown in four bits, so the field saturates at 15
    always_comb begin
        cnt_ext  = 5'(count);
        sts      = '0;
        sts[7]   = busy;
        sts[6]   = ovf_flag;
        sts[5]   = to_flag;
        sts[4]   = fifo_empty && !busy;
        sts[3:0] = cnt_ext[4] ? 4'hF : cnt_ext[3:0];
    end

endmodule

// File: tb/tb_coproc_cmd_sched.sv
// Directed, self-checking bench for coproc_cmd_sched: a vector table for the single-command
// flow plus hand-written sequences for overflow, full push+pop, flush, reset and timeout.
module tb_coproc_cmd_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_wr;
    logic [7:0] cmd_data;
    logic       flush;
    logic       sts_clr;
    logic       cp_rdy;
    logic       cp_done;
    logic       cp_start;
    logic       cp_gray;
    logic       cp_img_idx;
    logic [2:0] cp_func;
    logic [7:0] sts;
    logic       irq_done;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int irq_cnt = 0;
    logic [2:0] issued [64];

    coproc_cmd_sched #(
        .DEPTH     (4),
        .TO_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_wr     (cmd_wr),
        .cmd_data   (cmd_data),
        .flush      (flush),
        .sts_clr    (sts_clr),
        .cp_rdy     (cp_rdy),
        .cp_done    (cp_done),
        .cp_start   (cp_start),
        .cp_gray    (cp_gray),
        .cp_img_idx (cp_img_idx),
        .cp_func    (cp_func),
        .sts        (sts),
        .irq_done   (irq_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cp_start === 1'b1) begin
            if (start_cnt < 64) begin
                issued[start_cnt] <= cp_func;
            end
            start_cnt <= start_cnt + 1;
        end
        if (irq_done === 1'b1) begin
            irq_cnt <= irq_cnt + 1;
        end
    end

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       rdy;
        logic       done;
        logic       e_start;
        logic       e_irq;
        logic [7:0] e_sts;
        logic [4:0] e_fld;
    } vec_t;

    vec_t v [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        cmd_wr   = 1'b1;
        cmd_data = d;
        step();
        cmd_wr   = 1'b0;
        cmd_data = 8'h00;
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 40 && cp_start !== 1'b1; i++) begin
            step();
        end
        chk(name, 32'(cp_start), 32'd1);
    endtask

    task automatic finish_cmd(input int dly);
        repeat (dly) step();
        cp_done = 1'b1;
        step();
        chk("irq_done pulse", 32'(irq_done), 32'd1);
        cp_done = 1'b0;
    endtask

    initial begin
        int base;
        int ibase;

        rst_n    = 1'b0;
        cmd_wr   = 1'b0;
        cmd_data = 8'h00;
        flush    = 1'b0;
        sts_clr  = 1'b0;
        cp_rdy   = 1'b0;
        cp_done  = 1'b0;

        // single command 0x45: gray=1, img_idx=0, func=5 -> fields 5'b1_0_101
        v[0]  = '{1'b1, 8'h45, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 5'h00};
        v[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 5'h15};
        for (int i = 2; i < 12; i++) begin
            v[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 5'h15};
        end
        v[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 5'h15};
        v[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 5'h15};
        v[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 5'h15};

        repeat (2) step();
        chk("reset sts", 32'(sts), 32'h10);
        chk("reset start", 32'(cp_start), 32'd0);
        chk("reset irq", 32'(irq_done), 32'd0);
        chk("reset fields", 32'({cp_gray, cp_img_idx, cp_func}), 32'd0);
        rst_n = 1'b1;

        // ---- single command, table driven ----
        for (int i = 0; i < 15; i++) begin
            cmd_wr   = v[i].wr;
            cmd_data = v[i].d;
            cp_rdy   = v[i].rdy;
            cp_done  = v[i].done;
            step();
            chk($sformatf("vec%0d start", i), 32'(cp_start), 32'(v[i].e_start));
            chk($sformatf("vec%0d irq", i), 32'(irq_done), 32'(v[i].e_irq));
            chk($sformatf("vec%0d sts", i), 32'(sts), 32'(v[i].e_sts));
            chk($sformatf("vec%0d fields", i), 32'({cp_gray, cp_img_idx, cp_func}), 32'(v[i].e_fld));
        end
        cmd_wr = 1'b0;

        // ---- cp_done already high when RUN is entered ----
        cp_done = 1'b1;
        push(8'h2A);
        wait_start("prehigh start");
        chk("prehigh fields", 32'({cp_gray, cp_img_idx, cp_func}), 32'h0A);
        ibase = irq_cnt;
        repeat (5) step();
        chk("prehigh no irq", 32'(irq_cnt - ibase), 32'd0);
        chk("prehigh busy sts", 32'(sts), 32'h80);
        cp_done = 1'b0;
        step();
        finish_cmd(1);
        step();
        chk("prehigh end sts", 32'(sts), 32'h10);

        // ---- depth and overflow ----
        cp_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push(8'(i));
        end
        chk("overflow sts", 32'(sts), 32'h44);
        base = start_cnt;
        cp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start($sformatf("ovf start%0d", i));
            finish_cmd(2);
        end
        repeat (20) step();
        chk("ovf start count", 32'(start_cnt - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf order%0d", i), 32'(issued[base + i]), 32'(i + 1));
        end
        chk("ovf sticky", 32'(sts[6]), 32'd1);
        sts_clr = 1'b1;
        step();
        sts_clr = 1'b0;
        chk("sts_clr sts", 32'(sts), 32'h10);

        // ---- push and pop together at full ----
        cp_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(8'(i));
        end
        chk("full sts", 32'(sts), 32'h04);
        base = start_cnt;
        cp_rdy   = 1'b1;
        cmd_wr   = 1'b1;
        cmd_data = 8'h06;
        step();
        cmd_wr   = 1'b0;
        chk("full push+pop sts", 32'(sts), 32'h84);
        for (int i = 0; i < 5; i++) begin
            wait_start($sformatf("full start%0d", i));
            finish_cmd(1);
        end
        repeat (10) step();
        chk("full start count", 32'(start_cnt - base), 32'd5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("full order%0d", i), 32'(issued[base + i]), 32'(i + 1));
        end
        chk("full last cmd", 32'(issued[base + 4]), 32'd6);
        chk("full end sts", 32'(sts), 32'h10);

        // ---- flush during RUN ----
        base = start_cnt;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        chk("pre-flush sts", 32'(sts), 32'h82);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush sts", 32'(sts), 32'h80);
        finish_cmd(3);
        repeat (20) step();
        chk("flush start count", 32'(start_cnt - base), 32'd1);
        chk("flush end sts", 32'(sts), 32'h10);

        // ---- reset mid-operation ----
        push(8'h07);
        wait_start("rst start");
        step();
        cp_rdy = 1'b0;
        push(8'h01);
        push(8'h02);
        chk("rst pre sts", 32'(sts), 32'h82);
        #2 rst_n = 1'b0;
        #1;
        chk("rst sts", 32'(sts), 32'h10);
        chk("rst start", 32'(cp_start), 32'd0);
        chk("rst irq", 32'(irq_done), 32'd0);
        chk("rst fields", 32'({cp_gray, cp_img_idx, cp_func}), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cp_rdy = 1'b1;
        base = start_cnt;
        repeat (20) step();
        chk("rst no start", 32'(start_cnt - base), 32'd0);
        chk("rst end sts", 32'(sts), 32'h10);

`ifdef COPROC_SCHED_TIMEOUT_EN
        // ---- timeout with TO_CYCLES = 16 ----
        cp_rdy = 1'b0;
        push(8'h03);
        push(8'h04);
        cp_rdy = 1'b1;
        wait_start("to start");
        ibase = irq_cnt;
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("to busy%0d", i), 32'(sts[7]), 32'd1);
        end
        step();
        chk("to sts", 32'(sts), 32'h21);
        chk("to no irq", 32'(irq_cnt - ibase), 32'd0);
        step();
        chk("to next start", 32'(cp_start), 32'd1);
        chk("to next func", 32'(cp_func), 32'd4);
        finish_cmd(2);
        sts_clr = 1'b1;
        step();
        sts_clr = 1'b0;
        chk("to clr sts", 32'(sts), 32'h10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
